// File: rtl/periph_int_pkg.sv
// Shared definitions for the peripheral interrupt controller: register map,
// FSM encoding and source-count limits.
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 5
`endif

package periph_int_pkg;

    localparam int MAX_SRC = 31;
    localparam int IDX_W   = 5;

    localparam logic [3:0] ADDR_PEND   = 4'h0;
    localparam logic [3:0] ADDR_ENABLE = 4'h4;
    localparam logic [3:0] ADDR_CLAIM  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

    // Interrupt codes are 1-based so that 0 can mean "no request".
    function automatic logic [7:0] id_to_code(input logic [IDX_W-1:0] id);
        return 8'(id) + 8'd1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the request vector.
module int_prio_enc
    import periph_int_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] && !o_valid) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/periph_int_ctrl.sv
// Peripheral interrupt controller: pending/enable registers, one-at-a-time
// claim/complete handshake and a registered interrupt code for the CSR file.
`ifndef INT_CODE_WIDTH
`define INT_CODE_WIDTH 5
`endif

module periph_int_ctrl
    import periph_int_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int CODE_W  = `INT_CODE_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               reg_wr_en,
    input  logic               reg_rd_en,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic [CODE_W-1:0]  peripheral_int_code
);

    state_t               r_state;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_enable;
    logic [NUM_SRC-1:0]   r_in_service;
    logic [IDX_W-1:0]     r_sel_id;
    logic [CODE_W-1:0]    r_code;

    logic [NUM_SRC-1:0]   w_set;
    logic [NUM_SRC-1:0]   w_cand;
    logic [NUM_SRC-1:0]   w_sel_onehot;
    logic                 w_cand_valid;
    logic [IDX_W-1:0]     w_cand_idx;
    logic [7:0]           w_sel_code;
    logic                 w_claim;
    logic                 w_complete;
    logic                 w_en_wr;
    logic                 w_unused;

    assign w_unused     = ^reg_wdata;
    assign w_set        = irq_in & r_enable & ~r_pending & ~r_in_service;
    assign w_cand       = r_pending & r_enable;
    assign w_sel_onehot = NUM_SRC'(1) << r_sel_id;
    assign w_sel_code   = id_to_code(r_sel_id);
    assign w_en_wr      = reg_wr_en && (reg_addr == ADDR_ENABLE);

    // A read that coincides with a write returns data but never claims.
    assign w_claim    = reg_rd_en && !reg_wr_en && (reg_addr == ADDR_CLAIM) &&
                        (r_state == ST_ASSERT);
    assign w_complete = reg_wr_en && (reg_addr == ADDR_CLAIM) &&
                        (r_state == ST_CLAIMED) &&
                        (reg_wdata[CODE_W-1:0] == CODE_W'(w_sel_code));

    int_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .i_req   (w_cand),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_enable     <= '0;
            r_in_service <= '0;
            r_sel_id     <= '0;
            r_code       <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~(w_claim ? w_sel_onehot : '0);
            if (w_en_wr) begin
                r_enable <= reg_wdata[NUM_SRC-1:0];
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cand_valid) begin
                        r_sel_id <= w_cand_idx;
                        r_code   <= CODE_W'(id_to_code(w_cand_idx));
                        r_state  <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (w_claim) begin
                        r_in_service <= r_in_service | w_sel_onehot;
                        r_code       <= '0;
                        r_state      <= ST_CLAIMED;
                    end else if ((r_enable & w_sel_onehot) == '0) begin
                        r_code  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLAIMED: begin
                    if (w_complete) begin
                        r_in_service <= r_in_service & ~w_sel_onehot;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_code  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (rst && reg_rd_en) begin
            unique case (reg_addr)
                ADDR_PEND:   reg_rdata = 32'(r_pending);
                ADDR_ENABLE: reg_rdata = 32'(r_enable);
                ADDR_CLAIM:  reg_rdata = (r_state == ST_ASSERT) ? 32'(w_sel_code) : '0;
                ADDR_STATUS: reg_rdata = {22'd0, r_state, w_sel_code};
                default:     reg_rdata = '0;
            endcase
        end
    end

    assign peripheral_int_code = r_code;

endmodule

// File: tb/tb_periph_int_ctrl.sv
// Directed table-driven bench for periph_int_ctrl plus reset and latency sequences.
module tb_periph_int_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [4:0]  peripheral_int_code;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  irq;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  exp_code;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    periph_int_ctrl #(
        .NUM_SRC (8),
        .CODE_W  (5)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .irq_in              (irq_in),
        .reg_wr_en           (reg_wr_en),
        .reg_rd_en           (reg_rd_en),
        .reg_addr            (reg_addr),
        .reg_wdata           (reg_wdata),
        .reg_rdata           (reg_rdata),
        .peripheral_int_code (peripheral_int_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] irq, input logic wr, input logic rd,
                                input logic [3:0] addr, input logic [31:0] wdata,
                                input logic [4:0] code, input logic [31:0] rdata);
        vec_t v;
        v.irq = irq; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.exp_code = code; v.exp_rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [7:0] irq, input logic wr, input logic rd,
                         input logic [3:0] addr, input logic [31:0] wdata);
        irq_in = irq; reg_wr_en = wr; reg_rd_en = rd; reg_addr = addr; reg_wdata = wdata;
    endtask

    int cycles;

    initial begin
        // Each row: inputs held for one cycle; expectations reflect state before that edge.
        add(8'h00, 1, 0, 4'h4, 32'h05,       0, 32'h000);
        add(8'h04, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h04, 0, 1, 4'h0, 32'h0,        0, 32'h004);
        add(8'h00, 0, 1, 4'hC, 32'h0,        3, 32'h103);
        add(8'h00, 0, 1, 4'h8, 32'h0,        3, 32'h003);
        add(8'h00, 0, 1, 4'h8, 32'h0,        0, 32'h000);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h203);
        add(8'h00, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h00, 1, 0, 4'h8, 32'h5,        0, 32'h000);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h203);
        add(8'h00, 1, 0, 4'h8, 32'h3,        0, 32'h000);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h003);
        add(8'h05, 1, 0, 4'h4, 32'hFF,       0, 32'h000);
        add(8'h05, 0, 1, 4'h4, 32'h0,        0, 32'h0FF);
        add(8'h00, 0, 1, 4'h0, 32'h0,        1, 32'h005);
        add(8'h00, 0, 1, 4'h8, 32'h0,        1, 32'h001);
        add(8'h00, 0, 1, 4'h0, 32'h0,        0, 32'h004);
        add(8'h00, 1, 0, 4'h8, 32'h1,        0, 32'h000);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h001);
        add(8'h00, 0, 1, 4'hC, 32'h0,        3, 32'h103);
        add(8'h00, 1, 0, 4'h4, 32'h0,        3, 32'h000);
        add(8'h00, 0, 1, 4'hC, 32'h0,        3, 32'h103);
        add(8'h00, 0, 1, 4'h0, 32'h0,        0, 32'h004);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h003);
        add(8'h00, 1, 0, 4'h4, 32'hFFFFFFFF, 0, 32'h000);
        add(8'h00, 0, 1, 4'h4, 32'h0,        0, 32'h0FF);
        add(8'h00, 1, 1, 4'h8, 32'h0,        3, 32'h003);
        add(8'h00, 0, 1, 4'hC, 32'h0,        3, 32'h103);
        add(8'h00, 0, 1, 4'h8, 32'h0,        3, 32'h003);
        add(8'h00, 1, 0, 4'h8, 32'h3,        0, 32'h000);
        add(8'h00, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h02, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h02, 0, 1, 4'h0, 32'h0,        0, 32'h002);
        add(8'h02, 0, 1, 4'h8, 32'h0,        2, 32'h002);
        add(8'h02, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h02, 1, 0, 4'h8, 32'h2,        0, 32'h000);
        add(8'h02, 0, 1, 4'h0, 32'h0,        0, 32'h000);
        add(8'h02, 0, 1, 4'h0, 32'h0,        0, 32'h002);
        add(8'h00, 0, 1, 4'hC, 32'h0,        2, 32'h102);
        add(8'h00, 0, 1, 4'h8, 32'h0,        2, 32'h002);
        add(8'h00, 0, 1, 4'hC, 32'h0,        0, 32'h202);

        rst = 1'b0;
        drive(8'h00, 0, 1, 4'hC, 32'h0);
        #1;
        check("rdata_in_reset", reg_rdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_code", 32'(peripheral_int_code), 32'h0);
        rst = 1'b1;
        drive(8'h00, 0, 1, 4'h0, 32'h0);
        #1;
        check("reset_pending", reg_rdata, 32'h0);
        reg_addr = 4'h4;
        #1;
        check("reset_enable", reg_rdata, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].irq, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_code", i), 32'(peripheral_int_code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
            @(posedge clk); #1;
        end

        // Reset while a claim is outstanding.
        rst = 1'b0;
        drive(8'h02, 0, 1, 4'hC, 32'h0);
        #1;
        check("midclaim_rst_status", reg_rdata, 32'h0);
        @(posedge clk); #1;
        check("midclaim_rst_code", 32'(peripheral_int_code), 32'h0);
        rst = 1'b1;
        reg_addr = 4'h0;
        #1;
        check("post_rst_pending", reg_rdata, 32'h0);
        reg_addr = 4'h4;
        #1;
        check("post_rst_enable", reg_rdata, 32'h0);
        reg_addr = 4'h8;
        #1;
        check("post_rst_claim", reg_rdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reg_addr = 4'h0;
        #1;
        check("disabled_no_pend", reg_rdata, 32'h0);
        check("disabled_code", 32'(peripheral_int_code), 32'h0);

        // Highest index source: two edges from irq to code.
        drive(8'h00, 1, 0, 4'h4, 32'h80);
        @(posedge clk); #1;
        drive(8'h80, 0, 0, 4'h0, 32'h0);
        cycles = 0;
        while (peripheral_int_code != 5'd8 && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("irq7_latency", 32'(cycles), 32'd2);
        check("irq7_code", 32'(peripheral_int_code), 32'd8);
        drive(8'h00, 0, 1, 4'h8, 32'h0);
        #1;
        check("irq7_claim", reg_rdata, 32'd8);
        @(posedge clk); #1;
        check("irq7_code_after_claim", 32'(peripheral_int_code), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_int_ctrl.md
PERIPH_INT_CTRL -- requirements
Module: periph_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of peripheral interrupt sources (1..31).
REQ-002 SHALL have parameter CODE_W, default `INT_CODE_WIDTH, width of the interrupt code.
REQ-003 SHALL have port clk  input  1  core clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port irq_in  input  NUM_SRC  level-sensitive peripheral requests, already synchronous to clk.
REQ-006 SHALL have port reg_wr_en  input  1  register write strobe.
REQ-007 SHALL have port reg_rd_en  input  1  register read strobe.
REQ-008 SHALL have port reg_addr  input  4  byte offset: 0x0 pending (RO), 0x4 enable (RW), 0x8 claim/complete, 0xC status (RO).
REQ-009 SHALL have port reg_wdata  input  32  write data.
REQ-010 SHALL have port reg_rdata  output  32  read data.
REQ-011 SHALL have port peripheral_int_code  output  CODE_W  code for the CSR file: source index+1, or 0 when no request.

Function
REQ-012 SHALL set pending[i] at the clk edge where irq_in[i]=1, enable[i]=1, pending[i]=0 and source i is not in service.
REQ-013 SHALL hold pending[i] until claimed; deasserting irq_in SHALL NOT clear it.
REQ-014 SHALL run FSM IDLE -> ASSERT -> CLAIMED -> IDLE; encoding 2 bits.
REQ-015 IDLE: if any pending&enable, SHALL latch sel_id = lowest such index and enter ASSERT next edge; fixed priority, index 0 highest.
REQ-016 ASSERT: peripheral_int_code SHALL equal sel_id+1 (registered output); in all other states it SHALL be 0.
REQ-017 ASSERT: if enable[sel_id] is cleared before a claim, SHALL return to IDLE next edge; pending bit retained.
REQ-018 Claim = reg_rd_en with reg_addr 0x8 in ASSERT: reg_rdata=sel_id+1 same cycle; at the edge, pending[sel_id] cleared, in_service[sel_id] set, state to CLAIMED.
REQ-019 Claim read in IDLE or CLAIMED SHALL return 0 with no side effect.
REQ-020 Complete = reg_wr_en, reg_addr 0x8, reg_wdata[CODE_W-1:0]==sel_id+1, in CLAIMED: SHALL clear in_service[sel_id] and go to IDLE next edge.
REQ-021 Complete with mismatched id or outside CLAIMED SHALL be ignored.
REQ-022 Only one source SHALL be in service at a time; no nesting.
REQ-023 reg_rdata SHALL be combinational from reg_addr when reg_rd_en=1, else 0; 0x0 returns pending, 0x4 enable, 0xC {state[1:0] in [9:8], sel_id+1 in [7:0]}, zero-extended.
REQ-024 Enable write SHALL take effect at the edge; bits >= NUM_SRC ignored, read back 0.
REQ-025 reg_rd_en and reg_wr_en together: write SHALL proceed, read SHALL return data but have no side effect.
REQ-026 Latency: irq_in rising at edge N-1 sampled at N -> pending at N -> ASSERT and code valid after edge N+1.
REQ-027 Source re-raising while in service SHALL not pend until complete; if still high after complete, SHALL pend on the next edge.

Reset
REQ-028 On rst=0 at a clk edge: pending=0, enable=0, in_service=0, sel_id=0, state=IDLE, peripheral_int_code=0; applies mid-claim too.
REQ-029 reg_rdata SHALL read 0 during reset.

Structure
REQ-030 Register offsets, FSM state encoding and NUM_SRC maximum SHALL live in shared package/include periph_int_pkg.
REQ-031 Lowest-index selection SHALL be a combinational sub-module int_prio_enc (input NUM_SRC vector, output valid + index).
REQ-032 Expected size 150-300 lines RTL.

Verification
REQ-033 enable=0x05, irq_in[2]=1 -> code 3 two edges later; claim read 0x8 returns 3; code 0 next cycle.
REQ-034 irq_in[0] and irq_in[2] together, enable=0xFF -> code 1; after claim/complete(1), code 3 follows.
REQ-035 Complete with wdata=5 while sel_id+1=3 -> state stays CLAIMED; wdata=3 -> IDLE.
REQ-036 In ASSERT, write enable=0 -> IDLE, code 0, pending read 0x0 still shows bit.
REQ-037 rst=0 during CLAIMED -> all registers 0, code 0, status reads 0.
REQ-038 irq_in[1] held high through claim/complete -> re-pends one edge after complete, code 2 again.
